branch_resolver: RTL and testbench

- Client side of the 2-bit branch predictor interface.
- Issues prediction requests for fetched branches and captures each returned prediction into an in-order tracking FIFO.
- When execute resolves the oldest branch, the block compares the outcome with the stored prediction, sends the result/taken update back to the predictor, and flags mispredicts.
- Sits between fetch/execute and the predictor.

---
 rtl/branch_resolver.sv | 137 +++++++++++++
 tb/tb_branch_resolver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Client side of the 2-bit branch predictor: tracks in-flight branch predictions in order,
// resolves them against execute outcomes and flushes on mispredict. Optional stats: BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             resolve_ready,
    output logic             pred_request,
    input  logic             pred_in,
    output logic             pred_result,
    output logic             pred_taken,
    output logic             fetch_pred,
    output logic             fetch_pred_valid,
    output logic             mispredict,
    output logic [PTR_W:0]   occupancy
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    input  logic             stat_clear,
    output logic [31:0]      stat_resolved,
    output logic [31:0]      stat_mispredict
`endif
);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_pending;
    logic [DEPTH-1:0] ent_pred;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] cap_ptr;
    logic             cap_pending;

    logic accept;
    logic pop;
    logic flush;

    // issue_ready looks only at registered occupancy, so a same-cycle resolve cannot reopen it.
    assign issue_ready   = occupancy < (PTR_W+1)'(DEPTH);
    assign pred_request  = issue_valid & issue_ready;
    assign resolve_ready = ent_valid[head] & ~ent_pending[head];

    assign accept = pred_request;
    assign pop    = resolve_valid & resolve_ready;
    assign flush  = pop & (resolve_taken != ent_pred[head]);

    // NOTE: the entry flags are few flops, so they are reset with the pointers; a flush or reset then leaves no stale valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid   <= '0;
            ent_pending <= '0;
            ent_pred    <= '0;
            head        <= '0;
            tail        <= '0;
            cap_ptr     <= '0;
            cap_pending <= 1'b0;
            occupancy   <= '0;
        end else begin
            // NOTE: non-blocking assignments let the flush branch below override earlier updates (last assignment wins).
            if (cap_pending) begin
                ent_pred[cap_ptr]    <= pred_in;
                ent_pending[cap_ptr] <= 1'b0;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (accept) begin
                ent_valid[tail]   <= 1'b1;
                ent_pending[tail] <= 1'b1;
                tail              <= tail + PTR_W'(1);
                cap_ptr           <= tail;
            end
            cap_pending <= accept;

            case ({accept, pop})
                2'b10:   occupancy <= occupancy + (PTR_W+1)'(1);
                2'b01:   occupancy <= occupancy - (PTR_W+1)'(1);
                default: occupancy <= occupancy;
            endcase

            // A mispredict discards every younger entry, including a same-cycle issue.
            if (flush) begin
                ent_valid   <= '0;
                ent_pending <= '0;
                head        <= '0;
                tail        <= '0;
                cap_pending <= 1'b0;
                occupancy   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_result      <= 1'b0;
            pred_taken       <= 1'b0;
            mispredict       <= 1'b0;
            fetch_pred       <= 1'b0;
            fetch_pred_valid <= 1'b0;
        end else begin
            pred_result <= pop;
            if (pop) begin
                pred_taken <= resolve_taken;
            end
            mispredict       <= flush;
            fetch_pred_valid <= cap_pending & ~flush;
            if (cap_pending & ~flush) begin
                fetch_pred <= pred_in;
            end
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else if (stat_clear) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (pred_result) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (mispredict) begin
                stat_mispredict <= stat_mispredict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_branch_resolver;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic           clk;
    logic           rst_n;
    logic           issue_valid;
    logic           issue_ready;
    logic           resolve_valid;
    logic           resolve_taken;
    logic           resolve_ready;
    logic           pred_request;
    logic           pred_in;
    logic           pred_result;
    logic           pred_taken;
    logic           fetch_pred;
    logic           fetch_pred_valid;
    logic           mispredict;
    logic [PTR_W:0] occupancy;

    int passed = 0;
    int total  = 0;

    branch_resolver #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_ready    (resolve_ready),
        .pred_request     (pred_request),
        .pred_in          (pred_in),
        .pred_result      (pred_result),
        .pred_taken       (pred_taken),
        .fetch_pred       (fetch_pred),
        .fetch_pred_valid (fetch_pred_valid),
        .mispredict       (mispredict),
        .occupancy        (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of in-flight branches; -1 means the prediction is not yet captured.
    int fifo[$];
    bit m_cap, m_res, m_taken, m_mis, m_fp, m_fpv;
    bit m_acc, m_hs, m_flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo.delete();
            m_cap = 0; m_res = 0; m_taken = 0; m_mis = 0; m_fp = 0; m_fpv = 0;
        end else begin
            m_acc   = issue_valid && (fifo.size() < DEPTH);
            m_hs    = resolve_valid && (fifo.size() > 0) && (fifo[0] >= 0);
            m_flush = m_hs && (fifo[0] != int'(resolve_taken));
            m_res = m_hs;
            if (m_hs) m_taken = resolve_taken;
            m_mis = m_flush;
            m_fpv = m_cap && !m_flush;
            if (m_fpv) m_fp = pred_in;
            if (m_cap) fifo[fifo.size()-1] = int'(pred_in);
            if (m_hs) void'(fifo.pop_front());
            if (m_flush) begin
                fifo.delete();
                m_cap = 0;
            end else begin
                if (m_acc) fifo.push_back(-1);
                m_cap = m_acc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("issue_ready", 32'(issue_ready), 32'(fifo.size() < DEPTH));
            check("resolve_ready", 32'(resolve_ready), 32'((fifo.size() > 0) && (fifo[0] >= 0)));
            check("pred_request", 32'(pred_request), 32'(issue_valid && (fifo.size() < DEPTH)));
            check("occupancy", 32'(occupancy), 32'(fifo.size()));
            check("pred_result", 32'(pred_result), 32'(m_res));
            check("pred_taken", 32'(pred_taken), 32'(m_taken));
            check("mispredict", 32'(mispredict), 32'(m_mis));
            check("fetch_pred_valid", 32'(fetch_pred_valid), 32'(m_fpv));
            check("fetch_pred", 32'(fetch_pred), 32'(m_fp));
        end
    end

    // Predictor stand-in: the prediction for a request appears on pred_in the following cycle.
    logic req_q = 1'b0;
    logic np_q  = 1'b0;

    task automatic tick(input logic iv, input logic rv, input logic rt, input logic np);
        @(posedge clk);
        #1;
        if (req_q) pred_in = np_q;
        issue_valid   = iv;
        resolve_valid = rv;
        resolve_taken = rt;
        np_q          = np;
        @(negedge clk);
        req_q = pred_request;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        pred_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst occupancy", 32'(occupancy), 32'd0);
        check("rst issue_ready", 32'(issue_ready), 32'd1);
        check("rst fetch_pred_valid", 32'(fetch_pred_valid), 32'd0);
        check("rst pred_result", 32'(pred_result), 32'd0);

        // Single branch, predictor says taken.
        tick(1, 0, 0, 1);
        check("t1 pred_request", 32'(pred_request), 32'd1);
        idle(1);
        check("t1 occupancy", 32'(occupancy), 32'd1);
        check("t1 pending resolve_ready", 32'(resolve_ready), 32'd0);
        idle(1);
        check("t1 fetch_pred", 32'(fetch_pred), 32'd1);
        check("t1 fetch_pred_valid", 32'(fetch_pred_valid), 32'd1);
        idle(1);
        check("t1 fetch_pred_valid drop", 32'(fetch_pred_valid), 32'd0);

        // Correct resolve.
        tick(0, 1, 1, 0);
        check("t2 resolve_ready", 32'(resolve_ready), 32'd1);
        idle(1);
        check("t2 pred_result", 32'(pred_result), 32'd1);
        check("t2 pred_taken", 32'(pred_taken), 32'd1);
        check("t2 mispredict", 32'(mispredict), 32'd0);
        check("t2 occupancy", 32'(occupancy), 32'd0);

        // Mispredict flush.
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 1);
        idle(2);
        tick(0, 1, 0, 0);
        check("t3 occupancy", 32'(occupancy), 32'd3);
        tick(0, 1, 0, 0);
        check("t3 mispredict", 32'(mispredict), 32'd1);
        check("t3 pred_taken", 32'(pred_taken), 32'd0);
        check("t3 occupancy flushed", 32'(occupancy), 32'd0);
        check("t3 resolve_ready a", 32'(resolve_ready), 32'd0);
        tick(0, 1, 0, 0);
        check("t3 resolve_ready b", 32'(resolve_ready), 32'd0);
        check("t3 no second result", 32'(pred_result), 32'd0);
        idle(1);

        // Full.
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        check("t4 full issue_ready", 32'(issue_ready), 32'd0);
        check("t4 full pred_request", 32'(pred_request), 32'd0);
        check("t4 full occupancy", 32'(occupancy), 32'd4);
        tick(1, 1, 1, 1);
        check("t4 same-cycle issue_ready", 32'(issue_ready), 32'd0);
        check("t4 full resolve_ready", 32'(resolve_ready), 32'd1);
        idle(1);
        check("t4 reopened issue_ready", 32'(issue_ready), 32'd1);
        check("t4 occupancy 3", 32'(occupancy), 32'd3);
        for (int i = 0; i < 3; i++) tick(0, 1, 1, 0);
        idle(1);
        check("t4 drained", 32'(occupancy), 32'd0);

        // Simultaneous issue and resolve.
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 0);
        idle(2);
        tick(1, 1, 1, 1);
        check("t5 occupancy before", 32'(occupancy), 32'd2);
        idle(1);
        check("t5 occupancy kept", 32'(occupancy), 32'd2);
        check("t5 mispredict", 32'(mispredict), 32'd0);
        idle(1);
        check("t5 fetch_pred_valid", 32'(fetch_pred_valid), 32'd1);
        tick(1, 1, 1, 1);
        check("t5 req fires", 32'(pred_request), 32'd1);
        idle(1);
        check("t5 flush occupancy", 32'(occupancy), 32'd0);
        check("t5 flush mispredict", 32'(mispredict), 32'd1);
        idle(1);
        check("t5 dropped fetch_pred_valid", 32'(fetch_pred_valid), 32'd0);

        // Asynchronous reset while pred_result is high.
        tick(1, 0, 0, 1);
        idle(2);
        tick(1, 1, 1, 1);
        idle(1);
        check("t6 pred_result before", 32'(pred_result), 32'd1);
        check("t6 occupancy before", 32'(occupancy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async pred_result", 32'(pred_result), 32'd0);
        check("t6 async occupancy", 32'(occupancy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Post-reset sanity: not-taken prediction resolved not-taken.
        tick(1, 0, 0, 0);
        idle(2);
        check("t7 fetch_pred", 32'(fetch_pred), 32'd0);
        check("t7 fetch_pred_valid", 32'(fetch_pred_valid), 32'd1);
        tick(0, 1, 0, 0);
        idle(1);
        check("t7 pred_result", 32'(pred_result), 32'd1);
        check("t7 mispredict", 32'(mispredict), 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
